// File: rtl/bk_nibble_accumulator.sv
// bk_nibble_accumulator
//
// Accumulates a stream of operands into a W-bit running sum (W = 4*NIBBLES).
// A single 4-bit add slice (a + b + carry-in) is reused over NIBBLES cycles
// for each operand, least-significant nibble first.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   ena        design enable; low freezes all state (out_valid forced to 0)
//   clr        clear accumulator and overflow flag (honoured only when idle)
//   in_valid   operand valid
//   in_data    operand, W bits
//   in_ready   combinational: ena & ~clr & idle
//   acc_out    accumulator value (partial while busy)
//   out_valid  one-cycle strobe: accumulation complete
//   ovf        sticky carry-out of bit W-1
//   busy       combinational: add in progress

module bk_nibble_accumulator #(
    parameter int unsigned NIBBLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 in_ready,
    output logic [4*NIBBLES-1:0] acc_out,
    output logic                 out_valid,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [0:0] {StIdle, StAdd} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;

    logic [3:0] acc_nib, opnd_nib;
    logic [4:0] sum;

    // Shared nibble slice, selected by the current nibble index.
    assign acc_nib  = acc_q[4*idx_q +: 4];
    assign opnd_nib = opnd_q[4*idx_q +: 4];
    assign sum      = 5'(acc_nib) + 5'(opnd_nib) + 5'(carry_q);

    assign in_ready  = ena & ~clr & (state_q == StIdle);
    assign busy      = (state_q == StAdd);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        // Strobe defaults low, which also covers the ena-low case.
        out_valid_d = 1'b0;

        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (clr) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end else if (in_valid) begin
                        opnd_d  = in_data;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        state_d = StAdd;
                    end
                end
                StAdd: begin
                    acc_d[4*idx_q +: 4] = sum[3:0];
                    carry_d             = sum[4];
                    if (idx_q == LastIdx) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b1;
                        ovf_d       = ovf_q | sum[4];
                        carry_d     = 1'b0;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            opnd_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_bk_nibble_accumulator.sv
// Testbench for bk_nibble_accumulator: directed scenarios followed by random
// stimulus, every cycle compared against an arithmetic reference model.

module tb_bk_nibble_accumulator;

    localparam int unsigned NIBBLES = 3;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam longint unsigned FULL = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n, ena, clr, in_valid;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid, ovf, busy;
    logic [W-1:0] acc_out;

    bk_nibble_accumulator #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_on  = 1'b0;

    // Reference model: the sum is committed as a whole on completion; while
    // busy, the low 4*m_cnt bits already hold the new sum.
    longint unsigned m_acc  = 0;
    longint unsigned m_pend = 0;
    int unsigned     m_cnt  = 0;
    bit              m_busy = 1'b0;
    bit              m_ovf  = 1'b0;
    bit              m_ov   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned exp_acc();
        longint unsigned mask;
        if (!m_busy) return m_acc;
        mask = (64'd1 << (4 * m_cnt)) - 1;
        return ((m_acc & ~mask) | ((m_acc + m_pend) & mask)) & FULL;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit c, input bit v,
                              input longint unsigned d);
        longint unsigned s;
        if (!r) begin
            m_acc = 0; m_pend = 0; m_cnt = 0; m_busy = 0; m_ovf = 0; m_ov = 0;
        end else if (!e) begin
            m_ov = 0;
        end else if (!m_busy) begin
            m_ov = 0;
            if (c) begin
                m_acc = 0;
                m_ovf = 0;
            end else if (v) begin
                m_pend = d;
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            m_ov = 0;
            if (m_cnt == NIBBLES) begin
                s      = m_acc + m_pend;
                m_ovf  = m_ovf | (s > FULL);
                m_acc  = s & FULL;
                m_busy = 0;
                m_cnt  = 0;
                m_ov   = 1;
            end
        end
    endtask

    // Drive inputs for one cycle, check outputs mid-cycle, then advance.
    task automatic step(input bit r, input bit e, input bit c, input bit v,
                        input logic [W-1:0] d);
        rst_n    = r;
        ena      = e;
        clr      = c;
        in_valid = v;
        in_data  = d;
        #1;
        if (chk_on) begin
            check_eq("acc_out", 64'(acc_out), 64'(exp_acc()));
            check_eq("ovf", 64'(ovf), 64'(m_ovf));
            check_eq("out_valid", 64'(out_valid), 64'(m_ov));
            check_eq("busy", 64'(busy), 64'(m_busy));
            check_eq("in_ready", 64'(in_ready), 64'(e & ~c & ~m_busy));
        end
        @(posedge clk);
        model_edge(r, e, c, v, 64'(d));
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    endtask

    // Accept one operand and run until the completion cycle is visible.
    task automatic do_op(input logic [W-1:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b1, d);
        repeat (NIBBLES) idle();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk_on = 1'b1;

        // Reset state (also checked by the first idle step).
        idle();
        check_eq("rst_acc", 64'(acc_out), 64'h0);

        // Basic add.
        do_op(W'(12'h003));
        check_eq("basic_first", 64'(acc_out), 64'h003);
        do_op(W'(12'h001));
        check_eq("basic_sum", 64'(acc_out), 64'h004);
        check_eq("basic_ovf", 64'(ovf), 64'h0);

        // Carry chain across nibbles.
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        do_op(W'(12'h0FF));
        step(1'b1, 1'b1, 1'b0, 1'b1, W'(12'h001));
        idle();
        check_eq("carry_nib0", 64'(acc_out[3:0]), 64'h0);
        idle();
        idle();
        check_eq("carry_sum", 64'(acc_out), 64'h100);

        // Wrap and sticky overflow, then clear.
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        do_op(W'(12'hFFF));
        do_op(W'(12'h002));
        check_eq("wrap_sum", 64'(acc_out), 64'h001);
        check_eq("wrap_ovf", 64'(ovf), 64'h1);
        do_op(W'(12'h001));
        check_eq("sticky_ovf", 64'(ovf), 64'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check_eq("clr_ovf", 64'(ovf), 64'h0);
        check_eq("clr_acc", 64'(acc_out), 64'h0);

        // Backpressure: valid held for 12 cycles accepts exactly 3 operands.
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b1, W'(12'h005));
        check_eq("bp_acc", 64'(acc_out), 64'h00F);
        idle();

        // Enable dropped mid-add delays completion by two cycles.
        step(1'b1, 1'b1, 1'b0, 1'b1, W'(12'h001));
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle();
        check_eq("ena_not_done", 64'(out_valid), 64'h0);
        idle();
        check_eq("ena_done", 64'(out_valid), 64'h1);
        check_eq("ena_sum", 64'(acc_out), 64'h010);

        // Reset mid-add discards the operand.
        step(1'b1, 1'b1, 1'b0, 1'b1, W'(12'h007));
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle();
        check_eq("rst_mid_acc", 64'(acc_out), 64'h0);
        check_eq("rst_mid_busy", 64'(busy), 64'h0);

        // clr beats in_valid in idle.
        step(1'b1, 1'b1, 1'b1, 1'b1, W'(12'h009));
        check_eq("clr_win_busy", 64'(busy), 64'h0);

        // clr ignored while adding.
        step(1'b1, 1'b1, 1'b0, 1'b1, W'(12'h006));
        repeat (NIBBLES) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check_eq("clr_add_sum", 64'(acc_out), 64'h006);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 1) == 1),
                 W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
